// File: rtl/ring_counter_pkg.sv
// Shared types and default sizing for the adder ring-oscillator edge counter.
package ring_counter_pkg;

   typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} rc_state_t;

   localparam int DEF_COUNT_W       = 32;
   localparam int DEF_WINDOW_W      = 32;
   localparam int DEF_SETTLE_CYCLES = 4;
   localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/ring_edge_sync.sv
// Brings the asynchronous ring output into the clock domain and flags each rising
// edge with a single-cycle pulse.
module ring_edge_sync
   import ring_counter_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_chain,
   output logic o_edgePulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_chain};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_edgePulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/adder_ring_counter.sv
// Enables the adder ring, lets it settle, then counts its edges over a gated window.
// Define RING_COUNTER_SATURATE_EN for a saturating count with sticky overflow.
module adder_ring_counter
   import ring_counter_pkg::*;
#(
   parameter int COUNT_W       = DEF_COUNT_W,
   parameter int WINDOW_W      = DEF_WINDOW_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic                wb_clk_i,
   input  logic                reset,
   input  logic                start,
   input  logic [WINDOW_W-1:0] window_cycles,
   input  logic                chain_in,
   output logic                ring_en,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  count,
   output logic                overflow
);

   localparam logic [WINDOW_W-1:0] SETTLE_LOAD = WINDOW_W'(SETTLE_CYCLES - 1);

   rc_state_t           r_state;
   rc_state_t           w_nextState;
   logic [WINDOW_W-1:0] r_window;
   logic [WINDOW_W-1:0] r_timer;
   logic [COUNT_W-1:0]  r_count;
   logic                w_edgePulse;
   logic                w_timerZero;
   logic                w_startAccepted;

   ring_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edgeSync (
      .i_clk       (wb_clk_i),
      .i_reset     (reset),
      .i_chain     (chain_in),
      .o_edgePulse (w_edgePulse)
   );

   assign w_timerZero     = (r_timer == '0);
   assign w_startAccepted = (r_state == IDLE) && start;

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      ring_en     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = (window_cycles == '0) ? DONE : ARM;
            end
         end
         ARM: begin
            ring_en = 1'b1;
            busy    = 1'b1;
            if (w_timerZero) begin
               w_nextState = COUNT;
            end
         end
         COUNT: begin
            ring_en = 1'b1;
            busy    = 1'b1;
            if (w_timerZero) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // One down-counter times the settle period, then is reloaded for the window.
   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         r_window <= '0;
         r_timer  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_window <= window_cycles;
                  r_timer  <= SETTLE_LOAD;
               end
            end
            ARM: begin
               r_timer <= w_timerZero ? (r_window - 1'b1) : (r_timer - 1'b1);
            end
            COUNT: begin
               if (!w_timerZero) begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef RING_COUNTER_SATURATE_EN
   logic r_overflow;

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_startAccepted) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if ((r_state == COUNT) && w_edgePulse) begin
         if (&r_count) begin
            r_overflow <= 1'b1;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign overflow = r_overflow;
`else
   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_startAccepted) begin
         r_count <= '0;
      end else if ((r_state == COUNT) && w_edgePulse) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign overflow = 1'b0;
`endif

   assign count = r_count;

endmodule
